// File: rtl/riscv_core_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_core_pkg
//  Purpose  : Shared constants and helpers for the riscv_core pipeline:
//             opcode / funct3 encodings, ALU control codes, immediate formats.
//  Revision : 1.0  initial release
// ============================================================================
package riscv_core_pkg;

    // Major opcodes of the supported RV32I subset
    localparam logic [6:0] c_op_r      = 7'b0110011;
    localparam logic [6:0] c_op_i      = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;

    // funct3 encodings
    localparam logic [2:0] c_f3_add = 3'b000;
    localparam logic [2:0] c_f3_slt = 3'b010;
    localparam logic [2:0] c_f3_xor = 3'b100;
    localparam logic [2:0] c_f3_or  = 3'b110;
    localparam logic [2:0] c_f3_and = 3'b111;
    localparam logic [2:0] c_f3_lb  = 3'b000;
    localparam logic [2:0] c_f3_lw  = 3'b010;
    localparam logic [2:0] c_f3_sw  = 3'b010;
    localparam logic [2:0] c_f3_beq = 3'b000;
    localparam logic [2:0] c_f3_bne = 3'b001;

    // ALU control encodings
    localparam logic [2:0] c_alu_add = 3'b000;
    localparam logic [2:0] c_alu_sub = 3'b001;
    localparam logic [2:0] c_alu_and = 3'b010;
    localparam logic [2:0] c_alu_or  = 3'b011;
    localparam logic [2:0] c_alu_xor = 3'b100;
    localparam logic [2:0] c_alu_slt = 3'b101;

    // Immediate formats used by the decoder
    typedef enum logic [1:0] {
        IMM_I = 2'd0,
        IMM_S = 2'd1,
        IMM_B = 2'd2
    } imm_fmt_e;

    // Builds the sign-extended immediate from instr[31:20] (hi) and instr[11:7] (lo)
    function automatic logic [31:0] imm_extend(input logic [11:0] hi,
                                               input logic [4:0]  lo,
                                               input imm_fmt_e    fmt);
        logic [31:0] imm;
        case (fmt)
            IMM_S:   imm = {{20{hi[11]}}, hi[11:5], lo};
            IMM_B:   imm = {{19{hi[11]}}, hi[11], lo[0], hi[10:5], lo[4:1], 1'b0};
            default: imm = {{20{hi[11]}}, hi};
        endcase
        return imm;
    endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_core_alu.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_core_alu
//  Purpose  : 32-bit integer ALU with a zero flag for branch comparison.
//  Revision : 1.0  initial release
// ============================================================================
module riscv_core_alu
    import riscv_core_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  alu_control,
    output logic [31:0] result,
    output logic        zero
);

    // Select the operation; slt compares as signed values
    always_comb begin
        result = a + b;
        case (alu_control)
            c_alu_sub: result = a - b;
            c_alu_and: result = a & b;
            c_alu_or:  result = a | b;
            c_alu_xor: result = a ^ b;
            c_alu_slt: result = {31'd0, ($signed(a) < $signed(b))};
            default:   result = a + b;
        endcase
    end

    assign zero = (result == 32'd0);

endmodule
`default_nettype wire

// File: rtl/riscv_core_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_core_ctrl
//  Purpose  : Combinational main decoder. Unsupported encodings decode to a
//             bubble (no register write, no memory write, no branch).
//  Revision : 1.0  initial release
// ============================================================================
module riscv_core_ctrl
    import riscv_core_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic       reg_write,
    output logic       mem_write,
    output logic       load,
    output logic       byte_ld,
    output logic       alu_src,
    output logic [2:0] alu_control,
    output logic       branch,
    output logic       branch_ne,
    output imm_fmt_e   imm_fmt
);

    // Decode opcode/funct3/funct7[5] into the control word
    always_comb begin
        reg_write   = 1'b0;
        mem_write   = 1'b0;
        load        = 1'b0;
        byte_ld     = 1'b0;
        alu_src     = 1'b0;
        alu_control = c_alu_add;
        branch      = 1'b0;
        branch_ne   = 1'b0;
        imm_fmt     = IMM_I;
        case (opcode)
            c_op_r: begin
                reg_write = 1'b1;
                case (funct3)
                    c_f3_add: alu_control = funct7_5 ? c_alu_sub : c_alu_add;
                    c_f3_slt: alu_control = c_alu_slt;
                    c_f3_xor: alu_control = c_alu_xor;
                    c_f3_or:  alu_control = c_alu_or;
                    c_f3_and: alu_control = c_alu_and;
                    default:  reg_write   = 1'b0;
                endcase
            end
            c_op_i: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                case (funct3)
                    c_f3_add: alu_control = c_alu_add;
                    c_f3_slt: alu_control = c_alu_slt;
                    c_f3_xor: alu_control = c_alu_xor;
                    c_f3_or:  alu_control = c_alu_or;
                    c_f3_and: alu_control = c_alu_and;
                    default: begin
                        reg_write = 1'b0;
                        alu_src   = 1'b0;
                    end
                endcase
            end
            c_op_load: begin
                if (funct3 == c_f3_lw || funct3 == c_f3_lb) begin
                    reg_write = 1'b1;
                    load      = 1'b1;
                    alu_src   = 1'b1;
                    byte_ld   = (funct3 == c_f3_lb);
                end
            end
            c_op_store: begin
                if (funct3 == c_f3_sw) begin
                    mem_write = 1'b1;
                    alu_src   = 1'b1;
                    imm_fmt   = IMM_S;
                end
            end
            c_op_branch: begin
                if (funct3 == c_f3_beq || funct3 == c_f3_bne) begin
                    branch      = 1'b1;
                    branch_ne   = (funct3 == c_f3_bne);
                    alu_control = c_alu_sub;
                    imm_fmt     = IMM_B;
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/riscv_core.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_core
//  Purpose  : Four-stage (F, D, E/M, W) RV32I-subset core. No stalls:
//             W->E forwarding plus a write-through register file cover all
//             hazards; taken branches resolve in E and flush F/D and D/E.
//  Revision : 1.0  initial release
// ============================================================================
module riscv_core
    import riscv_core_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic [31:0] ReadData,
    output logic [31:0] pc,
    output logic [31:0] ALUOut,
    output logic [31:0] WriteData,
    output logic        MemWrite
);

    // ---------------- Fetch ----------------
    logic [31:0] r_pc;
    logic [31:0] w_pc_plus4;

    // ---------------- F/D ----------------
    logic [31:0] r_instr_d;
    logic [31:0] r_pc_d;

    // ---------------- Decode ----------------
    logic [4:0]  w_rs1_d, w_rs2_d, w_rd_d;
    logic        w_reg_write_d, w_mem_write_d, w_load_d, w_byte_d;
    logic        w_alu_src_d, w_branch_d, w_branch_ne_d;
    logic [2:0]  w_alu_control_d;
    imm_fmt_e    w_imm_fmt_d;
    logic [31:0] w_imm_d;
    logic [31:0] w_rd1_d, w_rd2_d;
    logic [31:0] r_regs [32];

    // ---------------- D/E ----------------
    logic        r_reg_write_e, r_mem_write_e, r_load_e, r_byte_e;
    logic        r_alu_src_e, r_branch_e, r_branch_ne_e;
    logic [2:0]  r_alu_control_e;
    logic [4:0]  r_rs1_e, r_rs2_e, r_rd_e;
    logic [31:0] r_rd1_e, r_rd2_e, r_imm_e, r_pc_e;

    // ---------------- Execute ----------------
    logic [31:0] w_src_a_e, w_fwd_b_e, w_src_b_e;
    logic [31:0] w_alu_result_e;
    logic        w_zero_e;
    logic        w_taken_e;
    logic [31:0] w_target_e;

    // ---------------- E/W ----------------
    logic        r_reg_write_w, r_load_w, r_byte_w;
    logic [4:0]  r_rd_w;
    logic [31:0] r_alu_w, r_read_w;
    logic [1:0]  r_lane_w;

    // ---------------- Writeback ----------------
    logic [7:0]  w_byte_w;
    logic [31:0] w_result_w;

    assign w_pc_plus4 = r_pc + 32'd4;

    // Program counter: redirect on a taken branch in E, otherwise sequential
    always_ff @(posedge clk) begin
        if (reset)          r_pc <= 32'd0;
        else if (w_taken_e) r_pc <= w_target_e;
        else                r_pc <= w_pc_plus4;
    end

    // F/D register; a zero word decodes as a bubble
    always_ff @(posedge clk) begin
        if (reset || w_taken_e) begin
            r_instr_d <= 32'd0;
            r_pc_d    <= 32'd0;
        end else begin
            r_instr_d <= instr;
            r_pc_d    <= r_pc;
        end
    end

    assign w_rs1_d = r_instr_d[19:15];
    assign w_rs2_d = r_instr_d[24:20];
    assign w_rd_d  = r_instr_d[11:7];

    riscv_core_ctrl u_ctrl (
        .opcode      (r_instr_d[6:0]),
        .funct3      (r_instr_d[14:12]),
        .funct7_5    (r_instr_d[30]),
        .reg_write   (w_reg_write_d),
        .mem_write   (w_mem_write_d),
        .load        (w_load_d),
        .byte_ld     (w_byte_d),
        .alu_src     (w_alu_src_d),
        .alu_control (w_alu_control_d),
        .branch      (w_branch_d),
        .branch_ne   (w_branch_ne_d),
        .imm_fmt     (w_imm_fmt_d)
    );

    assign w_imm_d = imm_extend(r_instr_d[31:20], r_instr_d[11:7], w_imm_fmt_d);

    // Register file reads: x0 is hard zero, a same-cycle W write is passed through
    always_comb begin
        w_rd1_d = r_regs[w_rs1_d];
        w_rd2_d = r_regs[w_rs2_d];
        if (r_reg_write_w && (r_rd_w == w_rs1_d)) w_rd1_d = w_result_w;
        if (r_reg_write_w && (r_rd_w == w_rs2_d)) w_rd2_d = w_result_w;
        if (w_rs1_d == 5'd0) w_rd1_d = 32'd0;
        if (w_rs2_d == 5'd0) w_rd2_d = 32'd0;
    end

    // Register file write at the end of W; reset suppresses any writeback
    always_ff @(posedge clk) begin
        if (!reset && r_reg_write_w && (r_rd_w != 5'd0)) begin
            r_regs[r_rd_w] <= w_result_w;
        end
    end

    // D/E register; cleared to an add-of-zero bubble on reset or flush
    always_ff @(posedge clk) begin
        if (reset || w_taken_e) begin
            r_reg_write_e   <= 1'b0;
            r_mem_write_e   <= 1'b0;
            r_load_e        <= 1'b0;
            r_byte_e        <= 1'b0;
            r_alu_src_e     <= 1'b0;
            r_branch_e      <= 1'b0;
            r_branch_ne_e   <= 1'b0;
            r_alu_control_e <= c_alu_add;
            r_rs1_e         <= 5'd0;
            r_rs2_e         <= 5'd0;
            r_rd_e          <= 5'd0;
            r_rd1_e         <= 32'd0;
            r_rd2_e         <= 32'd0;
            r_imm_e         <= 32'd0;
            r_pc_e          <= 32'd0;
        end else begin
            r_reg_write_e   <= w_reg_write_d;
            r_mem_write_e   <= w_mem_write_d;
            r_load_e        <= w_load_d;
            r_byte_e        <= w_byte_d;
            r_alu_src_e     <= w_alu_src_d;
            r_branch_e      <= w_branch_d;
            r_branch_ne_e   <= w_branch_ne_d;
            r_alu_control_e <= w_alu_control_d;
            r_rs1_e         <= w_rs1_d;
            r_rs2_e         <= w_rs2_d;
            r_rd_e          <= w_rd_d;
            r_rd1_e         <= w_rd1_d;
            r_rd2_e         <= w_rd2_d;
            r_imm_e         <= w_imm_d;
            r_pc_e          <= r_pc_d;
        end
    end

    // W->E forwarding for both source operands
    always_comb begin
        w_src_a_e = r_rd1_e;
        w_fwd_b_e = r_rd2_e;
        if (r_reg_write_w && (r_rd_w != 5'd0) && (r_rd_w == r_rs1_e)) w_src_a_e = w_result_w;
        if (r_reg_write_w && (r_rd_w != 5'd0) && (r_rd_w == r_rs2_e)) w_fwd_b_e = w_result_w;
    end

    assign w_src_b_e = r_alu_src_e ? r_imm_e : w_fwd_b_e;

    riscv_core_alu u_alu (
        .a           (w_src_a_e),
        .b           (w_src_b_e),
        .alu_control (r_alu_control_e),
        .result      (w_alu_result_e),
        .zero        (w_zero_e)
    );

    // beq takes on equal (zero), bne on not-equal
    assign w_taken_e  = r_branch_e & (w_zero_e ^ r_branch_ne_e);
    assign w_target_e = r_pc_e + r_imm_e;

    // E/W register; load data is captured at the end of E
    always_ff @(posedge clk) begin
        if (reset) begin
            r_reg_write_w <= 1'b0;
            r_load_w      <= 1'b0;
            r_byte_w      <= 1'b0;
            r_rd_w        <= 5'd0;
            r_alu_w       <= 32'd0;
            r_read_w      <= 32'd0;
            r_lane_w      <= 2'd0;
        end else begin
            r_reg_write_w <= r_reg_write_e;
            r_load_w      <= r_load_e;
            r_byte_w      <= r_byte_e;
            r_rd_w        <= r_rd_e;
            r_alu_w       <= w_alu_result_e;
            r_read_w      <= ReadData;
            r_lane_w      <= w_alu_result_e[1:0];
        end
    end

    // Writeback result: ALU value, load word, or sign-extended load byte
    always_comb begin
        case (r_lane_w)
            2'd0:    w_byte_w = r_read_w[7:0];
            2'd1:    w_byte_w = r_read_w[15:8];
            2'd2:    w_byte_w = r_read_w[23:16];
            default: w_byte_w = r_read_w[31:24];
        endcase
        if (!r_load_w)     w_result_w = r_alu_w;
        else if (r_byte_w) w_result_w = {{24{w_byte_w[7]}}, w_byte_w};
        else               w_result_w = r_read_w;
    end

    assign pc        = r_pc;
    assign ALUOut    = w_alu_result_e;
    assign WriteData = w_fwd_b_e;
    assign MemWrite  = r_mem_write_e;

endmodule
`default_nettype wire

// File: tb/tb_riscv_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riscv_core
//  Purpose  : Directed program vectors for riscv_core with behavioural
//             instruction and data memories.
//  Revision : 1.0  initial release
// ============================================================================
module tb_riscv_core;

    localparam logic [31:0] c_nop = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic [31:0] ReadData;
    logic [31:0] pc;
    logic [31:0] ALUOut;
    logic [31:0] WriteData;
    logic        MemWrite;

    logic [31:0] imem [64];
    logic [31:0] dmem [64];
    logic        init_req;
    logic [31:0] init_word;

    int tests_run;
    int tests_failed;

    typedef struct {
        string            name;
        logic [7:0][31:0] prog;
        logic [31:0]      mem4;
        int               nstores;
        logic [31:0]      addr;
        logic [31:0]      data;
    } vec_t;

    vec_t vecs[$];

    riscv_core dut (
        .clk       (clk),
        .reset     (reset),
        .instr     (instr),
        .ReadData  (ReadData),
        .pc        (pc),
        .ALUOut    (ALUOut),
        .WriteData (WriteData),
        .MemWrite  (MemWrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign instr    = imem[pc[7:2]];
    assign ReadData = dmem[ALUOut[7:2]];

    // Data memory: cleared on request, otherwise written by stores
    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < 64; i++) dmem[i] <= 32'd0;
            dmem[1] <= init_word;
        end else if (MemWrite) begin
            dmem[ALUOut[7:2]] <= WriteData;
        end
    end

    function automatic logic [31:0] f_i(input logic [6:0] op, input int rd, input int rs1,
                                        input logic [2:0] f3, input int imm);
        logic [31:0] v;
        v = imm;
        return {v[11:0], rs1[4:0], f3, rd[4:0], op};
    endfunction

    function automatic logic [31:0] f_r(input logic [6:0] f7, input int rs2, input int rs1,
                                        input logic [2:0] f3, input int rd);
        return {f7, rs2[4:0], rs1[4:0], f3, rd[4:0], 7'b0110011};
    endfunction

    function automatic logic [31:0] f_sw(input int rs2, input int rs1, input int imm);
        logic [31:0] v;
        v = imm;
        return {v[11:5], rs2[4:0], rs1[4:0], 3'b010, v[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] f_br(input logic [2:0] f3, input int rs1, input int rs2,
                                         input int imm);
        logic [31:0] v;
        v = imm;
        return {v[12], v[10:5], rs2[4:0], rs1[4:0], f3, v[4:1], v[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return f_i(7'b0010011, rd, rs1, 3'b000, imm);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name,
                           input logic [31:0] p0, input logic [31:0] p1,
                           input logic [31:0] p2, input logic [31:0] p3,
                           input logic [31:0] p4, input logic [31:0] p5,
                           input logic [31:0] mem4, input int nst,
                           input logic [31:0] a, input logic [31:0] d);
        vec_t v;
        v.name    = name;
        v.prog    = {c_nop, c_nop, p5, p4, p3, p2, p1, p0};
        v.mem4    = mem4;
        v.nstores = nst;
        v.addr    = a;
        v.data    = d;
        vecs.push_back(v);
    endtask

    // Loads memories and holds reset for two edges; returns at a falling edge with reset high
    task automatic init_dut(input logic [7:0][31:0] prog, input logic [31:0] mem4);
        for (int i = 0; i < 64; i++) imem[i] = c_nop;
        for (int k = 0; k < 8; k++) imem[k] = prog[k];
        init_word = mem4;
        init_req  = 1'b1;
        reset     = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_prog(input logic [7:0][31:0] prog, input logic [31:0] mem4,
                            output int nst, output logic [31:0] a, output logic [31:0] d);
        init_dut(prog, mem4);
        reset    = 1'b0;
        init_req = 1'b0;
        nst = 0;
        a   = 32'hDEAD_BEEF;
        d   = 32'hDEAD_BEEF;
        repeat (24) begin
            @(negedge clk);
            if (MemWrite) begin
                if (nst == 0) begin
                    a = ALUOut;
                    d = WriteData;
                end
                nst++;
            end
        end
    endtask

    initial begin
        logic [7:0][31:0] prog;
        int               nst;
        logic [31:0]      a, d;
        int               wr_count;

        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        init_req     = 1'b1;
        init_word    = 32'd0;

        // x1=-3, x2=5 set-up shared by the ALU vectors
        add_vec("fwd_chain", addi(1,0,5), addi(2,1,7), f_r(7'h00,2,1,3'b000,3), f_sw(3,0,84),
                c_nop, c_nop, 32'h0, 1, 32'd84, 32'd17);
        add_vec("lb_neg", f_i(7'b0000011,4,0,3'b000,4), f_sw(4,0,8), c_nop, c_nop, c_nop, c_nop,
                32'h0000_00F0, 1, 32'd8, 32'hFFFF_FFF0);
        add_vec("lw", f_i(7'b0000011,4,0,3'b010,4), f_sw(4,0,8), c_nop, c_nop, c_nop, c_nop,
                32'h0000_00F0, 1, 32'd8, 32'h0000_00F0);
        add_vec("lb_lane2", f_i(7'b0000011,4,0,3'b000,6), f_sw(4,0,12), c_nop, c_nop, c_nop, c_nop,
                32'h12B4_5678, 1, 32'd12, 32'hFFFF_FFB4);
        add_vec("sub", addi(1,0,-3), addi(2,0,5), f_r(7'h20,2,1,3'b000,3), f_sw(3,0,0),
                c_nop, c_nop, 32'h0, 1, 32'd0, 32'hFFFF_FFF8);
        add_vec("slt", addi(1,0,-3), addi(2,0,5), f_r(7'h00,2,1,3'b010,3), f_sw(3,0,0),
                c_nop, c_nop, 32'h0, 1, 32'd0, 32'd1);
        add_vec("and", addi(1,0,-3), addi(2,0,5), f_r(7'h00,2,1,3'b111,3), f_sw(3,0,0),
                c_nop, c_nop, 32'h0, 1, 32'd0, 32'd5);
        add_vec("or", addi(1,0,-3), addi(2,0,5), f_r(7'h00,2,1,3'b110,3), f_sw(3,0,0),
                c_nop, c_nop, 32'h0, 1, 32'd0, 32'hFFFF_FFFD);
        add_vec("xor", addi(1,0,-3), addi(2,0,5), f_r(7'h00,2,1,3'b100,3), f_sw(3,0,0),
                c_nop, c_nop, 32'h0, 1, 32'd0, 32'hFFFF_FFF8);
        add_vec("add", addi(1,0,-3), addi(2,0,5), f_r(7'h00,2,1,3'b000,3), f_sw(3,0,0),
                c_nop, c_nop, 32'h0, 1, 32'd0, 32'd2);
        add_vec("xori", addi(1,0,-3), f_i(7'b0010011,3,1,3'b100,32'h0F0), f_sw(3,0,4),
                c_nop, c_nop, c_nop, 32'h0, 1, 32'd4, 32'hFFFF_FF0D);
        add_vec("x0_write", addi(0,0,9), f_sw(0,0,0), c_nop, c_nop, c_nop, c_nop,
                32'h0, 1, 32'd0, 32'd0);
        add_vec("unknown_op", 32'h0000_007F, 32'h0000_007F, 32'h0000_007F, c_nop, c_nop, c_nop,
                32'h0, 0, 32'd0, 32'd0);
        add_vec("beq_taken", addi(1,0,1), addi(2,0,2), f_br(3'b000,0,0,12), f_sw(1,0,32),
                f_sw(1,0,36), f_sw(2,0,40), 32'h0, 1, 32'd40, 32'd2);
        add_vec("bne_not_taken", addi(1,0,1), f_br(3'b001,0,0,8), f_sw(1,0,12), c_nop,
                c_nop, c_nop, 32'h0, 1, 32'd12, 32'd1);
        add_vec("bne_taken", addi(1,0,1), f_br(3'b001,1,0,8), f_sw(1,0,16), f_sw(1,0,20),
                c_nop, c_nop, 32'h0, 1, 32'd20, 32'd1);
        add_vec("sw_neg_off", addi(1,0,100), addi(2,0,7), f_sw(2,1,-4), c_nop,
                c_nop, c_nop, 32'h0, 1, 32'd96, 32'd7);

        // Reset state and release: pc 0, 4, 8
        init_dut(vecs[0].prog, 32'h0);
        check("reset.pc", pc, 32'd0);
        check("reset.MemWrite", {31'd0, MemWrite}, 32'd0);
        check("reset.ALUOut", ALUOut, 32'd0);
        check("reset.WriteData", WriteData, 32'd0);
        reset    = 1'b0;
        init_req = 1'b0;
        check("release.ALUOut", ALUOut, 32'd0);
        @(negedge clk);
        check("release.pc1", pc, 32'd4);
        @(negedge clk);
        check("release.pc2", pc, 32'd8);

        // Table-driven program vectors
        foreach (vecs[i]) begin
            run_prog(vecs[i].prog, vecs[i].mem4, nst, a, d);
            check({vecs[i].name, ".stores"}, nst, vecs[i].nstores);
            if (vecs[i].nstores > 0) begin
                check({vecs[i].name, ".addr"}, a, vecs[i].addr);
                check({vecs[i].name, ".data"}, d, vecs[i].data);
            end
        end

        // Far branch: pc sequence and no write from the two flushed stores
        prog = {c_nop, c_nop, c_nop, f_sw(0,0,4), f_sw(0,0,0), f_br(3'b000,0,0,32), c_nop, c_nop};
        init_dut(prog, 32'h0);
        reset    = 1'b0;
        init_req = 1'b0;
        wr_count = 0;
        for (int k = 0; k < 7; k++) begin
            logic [31:0] exp_pc;
            exp_pc = (k < 5) ? 32'(4 * k) : 32'(40 + 4 * (k - 5));
            check($sformatf("branch.pc%0d", k), pc, exp_pc);
            if (MemWrite) wr_count++;
            @(negedge clk);
        end
        check("branch.flushed_writes", wr_count, 0);

        // Reset while the branch sits in E wins over the redirect
        init_dut(prog, 32'h0);
        reset    = 1'b0;
        init_req = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_branch.pc_before", pc, 32'd16);
        reset = 1'b1;
        @(negedge clk);
        check("rst_branch.pc", pc, 32'd0);
        check("rst_branch.MemWrite", {31'd0, MemWrite}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_branch.pc_next", pc, 32'd4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
